// File: rtl/seg7_scanner.sv
// seg7_scanner
//   Memory-mapped driver for an 8-digit common-anode seven-segment display.
//   Three write-only registers are loaded from the CPU IO bus:
//     LO   (addr 2'b00) nibbles for digits 0..3
//     HI   (addr 2'b10) nibbles for digits 4..7
//     CTRL (addr 2'b01) [7:0] digit mask (1 = lit), [15:8] decimal-point mask
//   A refresh counter keeps each digit slot active for REFRESH_DIV cycles and
//   then moves to the next digit. Masked slots stay dark but still take their
//   full share of time, so the duty cycle of the lit digits never changes.
//
// Ports
//   clock     system clock
//   rst       asynchronous active-high reset
//   segwrite  IO write strobe
//   segcs     chip select from the IO address decoder
//   segaddr   register select (low address bits)
//   segwdata  IO write data
//   seg_en    digit enables, active-low, bit i = digit i (registered)
//   seg_out   segments {dp,g,f,e,d,c,b,a}, active-low (registered)

module seg7_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        segwrite,
  input  logic        segcs,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam logic [1:0] ADDR_LO   = 2'b00;
  localparam logic [1:0] ADDR_CTRL = 2'b01;
  localparam logic [1:0] ADDR_HI   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [15:0]      lo_q, lo_d;
  logic [15:0]      hi_q, hi_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       dp_q, dp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_en_q, seg_en_d;
  logic [7:0]       seg_out_q, seg_out_d;

  logic [31:0]      digits;
  logic [3:0]       nibble;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Register writes. Address 2'b11 is decoded but deliberately does nothing.
  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    mask_d = mask_q;
    dp_d   = dp_q;
    if (segwrite && segcs) begin
      case (segaddr)
        ADDR_LO:   lo_d = segwdata;
        ADDR_HI:   hi_d = segwdata;
        ADDR_CTRL: begin
          mask_d = segwdata[7:0];
          dp_d   = segwdata[15:8];
        end
        default: ;
      endcase
    end
  end

  // Refresh counter; the digit index advances only on the wrap cycle, and the
  // 3-bit index wraps 7 -> 0 on its own.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Output pattern for the slot currently selected by idx_q. Registering it
  // gives one cycle of latency from any index change or register write.
  assign digits = {hi_q, lo_q};
  assign nibble = digits[{idx_q, 2'b00} +: 4];

  always_comb begin
    seg_en_d  = 8'hFF;
    seg_out_d = 8'hFF;
    if (mask_q[idx_q]) begin
      seg_en_d  = ~(8'b1 << idx_q);
      seg_out_d = ~{dp_q[idx_q], hex7(nibble)};
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lo_q      <= '0;
      hi_q      <= '0;
      mask_q    <= 8'hFF;
      dp_q      <= 8'h00;
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_en_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
    end else begin
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      mask_q    <= mask_d;
      dp_q      <= dp_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign seg_en  = seg_en_q;
  assign seg_out = seg_out_q;

endmodule
